sopc_button_pio: RTL and testbench

Parametrised Avalon-MM slave for push-button and switch inputs: the next generation of the read-only button PIO. It adds per-bit two-flop synchronisation, per-bit debounce, edge capture with write-1-to-clear, and an interrupt mask driving an IRQ. It sits in the SOPC system as a 32-bit slave next to the counter/PWM peripherals, with `in_port` wired to board buttons.

---
 rtl/sopc_pio_pkg.sv | 25 ++
 rtl/sopc_pio_debounce.sv | 73 +++++++
 rtl/sopc_button_pio.sv | 98 +++++++++
 tb/tb_sopc_button_pio.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sopc_pio_pkg.sv
// Shared constants for the button PIO: register addresses, edge-select codes
// and a constant-foldable ceiling log2.
package sopc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sopc_pio_debounce.sv
// One input bit: two-flop synchroniser, stability counter and debounced value,
// with single-cycle rise/fall pulses aligned to the edge where stable updates.
module sopc_pio_debounce
  import sopc_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VALUE     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;
  logic stable_reg;
  logic stable_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg     <= RESET_VALUE;
      s2_reg     <= RESET_VALUE;
      stable_reg <= RESET_VALUE;
    end else begin
      s1_reg     <= in_bit;
      s2_reg     <= s1_reg;
      stable_reg <= stable_next;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb begin
        stable_next = s2_reg;
      end
    end else begin : g_debounce
      localparam int CW = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;

      // Any sample matching the current stable value restarts the count.
      always_comb begin
        stable_next = stable_reg;
        count_next  = '0;
        if (s2_reg != stable_reg) begin
          if (count_reg == LAST) begin
            stable_next = s2_reg;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end
    end
  endgenerate

  assign stable = stable_reg;
  assign rise   = stable_next & ~stable_reg;
  assign fall   = ~stable_next & stable_reg;

endmodule

// File: rtl/sopc_button_pio.sv
// Avalon-MM button/switch PIO: debounced DATA, IRQ mask, sticky edge capture
// with write-1-to-clear, and a registered level interrupt.
module sopc_button_pio
  import sopc_pio_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic RISE_EN = (EDGE_TYPE != EDGE_FALL);
  localparam logic FALL_EN = (EDGE_TYPE != EDGE_RISE);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] captured;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] irqmask_next;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             irq_reg;
  logic             wr_en;
  logic             unused_writedata;

  // Bits of writedata above WIDTH are intentionally ignored.
  assign unused_writedata = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      sopc_pio_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (RESET_VALUE[gi])
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port[gi]),
        .stable  (stable[gi]),
        .rise    (rise[gi]),
        .fall    (fall[gi])
      );
      assign captured[gi] = (rise[gi] & RISE_EN) | (fall[gi] & FALL_EN);
    end
  endgenerate

  always_comb begin
    wr_en        = chipselect && !write_n;
    irqmask_next = irqmask_reg;
    edgecap_next = edgecap_reg;
    if (wr_en && address == ADDR_IRQMASK) begin
      irqmask_next = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGECAP) begin
      edgecap_next = edgecap_reg & ~writedata[WIDTH-1:0];
    end
    // A new edge in the same cycle as a clear must survive.
    edgecap_next = edgecap_next | captured;

    case (address)
      ADDR_DATA:    readdata_next = 32'(stable);
      ADDR_IRQMASK: readdata_next = 32'(irqmask_reg);
      ADDR_EDGECAP: readdata_next = 32'(edgecap_reg);
      default:      readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_reg  <= '0;
      edgecap_reg  <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      irqmask_reg  <= irqmask_next;
      edgecap_reg  <= edgecap_next;
      readdata_reg <= readdata_next;
      irq_reg      <= |(edgecap_reg & irqmask_reg);
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_sopc_button_pio.sv
// Bench for sopc_button_pio: falling-edge and any-edge instances share inputs;
// a sliding-window reference model feeds a scoreboard checked every cycle.
module tb_sopc_button_pio;

  localparam int DC = 16;
  localparam int HN = DC + 2;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata_fall;
  logic [31:0] readdata_any;
  logic        irq_fall;
  logic        irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  sopc_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1), .RESET_VALUE(2'b11)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_fall), .irq(irq_fall)
  );

  sopc_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2), .RESET_VALUE(2'b11)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_any), .irq(irq_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bit's debounced value flips once the last DC synchronised
  // samples all disagree with it; synchronised sample = input two edges back.
  typedef struct packed {
    logic [31:0] rd_fall;
    logic [31:0] rd_any;
    logic        irq_f;
    logic        irq_a;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] hist [HN];
  logic [1:0] m_stable;
  logic [1:0] m_mask;
  logic [1:0] m_ecap_f;
  logic [1:0] m_ecap_a;

  task automatic model_reset();
    for (int i = 0; i < HN; i++) hist[i] = 2'b11;
    m_stable = 2'b11;
    m_mask   = 2'b00;
    m_ecap_f = 2'b00;
    m_ecap_a = 2'b00;
    sb_q.delete();
  endtask

  function automatic logic [31:0] reg_view(input logic [1:0] a, input logic [1:0] ecap);
    case (a)
      2'd0:    return {30'd0, m_stable};
      2'd2:    return {30'd0, m_mask};
      2'd3:    return {30'd0, ecap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    exp_t       e;
    logic [1:0] nxt;
    logic [1:0] rose;
    logic [1:0] fell;
    logic [1:0] clr;
    logic       wr;
    bit         flip;
    e.rd_fall = reg_view(address, m_ecap_f);
    e.rd_any  = reg_view(address, m_ecap_a);
    e.irq_f   = |(m_ecap_f & m_mask);
    e.irq_a   = |(m_ecap_a & m_mask);
    for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = in_port;
    for (int b = 0; b < 2; b++) begin
      flip = 1'b1;
      for (int j = 2; j < HN; j++) if (hist[j][b] == m_stable[b]) flip = 1'b0;
      nxt[b] = flip ? ~m_stable[b] : m_stable[b];
    end
    rose = nxt & ~m_stable;
    fell = ~nxt & m_stable;
    wr   = chipselect && !write_n;
    clr  = (wr && address == 2'd3) ? writedata[1:0] : 2'b00;
    m_ecap_f = (m_ecap_f & ~clr) | fell;
    m_ecap_a = (m_ecap_a & ~clr) | rose | fell;
    if (wr && address == 2'd2) m_mask = writedata[1:0];
    m_stable = nxt;
    sb_q.push_back(e);
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_rd_fall", readdata_fall, e.rd_fall);
        check("sb_rd_any", readdata_any, e.rd_any);
        check("sb_irq_fall", {31'd0, irq_fall}, {31'd0, e.irq_f});
        check("sb_irq_any", {31'd0, irq_any}, {31'd0, e.irq_a});
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("WRITE addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a,
                        input logic [31:0] ef, input logic [31:0] ea);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check({nm, "_fall"}, readdata_fall, ef);
    check({nm, "_any"}, readdata_any, ea);
    $display("READ %s addr=%0d fall=0x%0h any=0x%0h", nm, a, readdata_fall, readdata_any);
  endtask

  task automatic chk_irq(input string nm, input logic ef, input logic ea);
    check({nm, "_fall"}, {31'd0, irq_fall}, {31'd0, ef});
    check({nm, "_any"}, {31'd0, irq_any}, {31'd0, ea});
    $display("IRQ %s fall=%0b any=%0b", nm, irq_fall, irq_any);
  endtask

  initial begin : stimulus
    reset_n = 1'b0; in_port = 2'b11; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;

    // Reset state
    hold(3);
    check("rst_rd_fall", readdata_fall, 32'd0);
    check("rst_rd_any", readdata_any, 32'd0);
    chk_irq("rst_irq", 1'b0, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    rd_chk("rst_data", 2'd0, 32'h3, 32'h3);
    rd_chk("rst_mask", 2'd2, 32'h0, 32'h0);
    rd_chk("rst_ecap", 2'd3, 32'h0, 32'h0);
    chk_irq("rst_irq_run", 1'b0, 1'b0);

    // Debounce latency: stable updates on edge 18, visible on readdata after edge 19
    @(negedge clk); address = 2'd0; in_port = 2'b10;
    hold(18);
    check("deb_before", readdata_fall, 32'h3);
    hold(1);
    check("deb_after", readdata_fall, 32'h2);
    rd_chk("deb_ecap", 2'd3, 32'h1, 32'h1);
    drive(2'b11); hold(20);
    bus_write(2'd3, 32'h3);

    // Glitch of 10 clocks is rejected
    drive(2'b01); hold(9); drive(2'b11); hold(25);
    rd_chk("glitch_data", 2'd0, 32'h3, 32'h3);
    rd_chk("glitch_ecap", 2'd3, 32'h0, 32'h0);

    // IRQ path: asserts the clock after capture, drops the clock after clear
    bus_write(2'd2, 32'h1);
    drive(2'b10); hold(18);
    chk_irq("irq_capture_edge", 1'b0, 1'b0);
    hold(1);
    chk_irq("irq_asserted", 1'b1, 1'b1);
    bus_write(2'd3, 32'h1);
    chk_irq("irq_clear_edge", 1'b1, 1'b1);
    hold(1);
    chk_irq("irq_cleared", 1'b0, 1'b0);
    drive(2'b11); hold(20);
    bus_write(2'd3, 32'h3);
    bus_write(2'd2, 32'h0);
    drive(2'b10); hold(20);
    chk_irq("irq_masked", 1'b0, 1'b0);
    rd_chk("masked_ecap", 2'd3, 32'h1, 32'h1);
    drive(2'b11); hold(20);
    bus_write(2'd3, 32'h3);

    // Clear and capture on the same edge: capture wins
    @(negedge clk); in_port = 2'b10;
    hold(17);
    address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    hold(1);
    chipselect = 1'b0; write_n = 1'b0 | 1'b1;
    $display("WRITE addr=3 data=0x00000001 (collision)");
    hold(1);
    check("collide_fall", readdata_fall, 32'h1);
    check("collide_any", readdata_any, 32'h1);
    drive(2'b11); hold(20);
    bus_write(2'd3, 32'h3);

    // Edge selection: falling-only vs any
    drive(2'b01); hold(20);
    rd_chk("press1_ecap", 2'd3, 32'h2, 32'h2);
    bus_write(2'd3, 32'h3);
    drive(2'b11); hold(20);
    rd_chk("release1_ecap", 2'd3, 32'h0, 32'h2);
    bus_write(2'd3, 32'h3);

    // Reset in the middle of a debounce count
    drive(2'b10); hold(10);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rd_fall", readdata_fall, 32'd0);
    check("midrst_rd_any", readdata_any, 32'd0);
    chk_irq("midrst_irq", 1'b0, 1'b0);
    in_port = 2'b11;
    hold(2);
    @(negedge clk); reset_n = 1'b1;
    rd_chk("midrst_data", 2'd0, 32'h3, 32'h3);
    rd_chk("midrst_ecap", 2'd3, 32'h0, 32'h0);

    // Writes to read-only and reserved addresses
    bus_write(2'd0, 32'h0);
    rd_chk("ro_data", 2'd0, 32'h3, 32'h3);
    bus_write(2'd1, 32'hFFFF_FFFF);
    rd_chk("reserved", 2'd1, 32'h0, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFE);
    rd_chk("mask_width", 2'd2, 32'h2, 32'h2);

    // Randomised traffic, checked by the scoreboard
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if ($urandom_range(0, 29) == 0) in_port = 2'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          chipselect = 1'b1; write_n = 1'b0;
          address = 2'($urandom); writedata = $urandom;
          $display("WRITE addr=%0d data=0x%08h (random)", address, writedata);
        end
        1: begin chipselect = 1'b1; address = 2'($urandom); writedata = $urandom; end
        2: begin write_n = 1'b0; address = 2'($urandom); writedata = $urandom; end
        default: address = 2'($urandom);
      endcase
    end
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    hold(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
